// File: rtl/io_port_unit.sv
// Buffered CPU I/O port: output FIFO drained by a valid/ready consumer, one-entry
// input holder filled by a valid/ready producer, with stall generation to the control FSM.
module io_port_unit #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned OUT_DEPTH     = 4,
  parameter bit          STALL_ON_FULL = 1'b1,
  parameter bit          BLOCKING_IN   = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cpu_out_wr,
  input  logic [DATA_WIDTH-1:0]        cpu_out_data,
  input  logic                         cpu_in_rd,
  output logic [DATA_WIDTH-1:0]        cpu_in_data,
  output logic                         cpu_stall,
  output logic [DATA_WIDTH-1:0]        out_last,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic                         overflow
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_valid;

  logic full;
  logic pop;
  logic push;
  logic blocked_wr;
  logic stall_full;
  logic stall_in;
  logic drop;
  logic hold_load;
  logic hold_consume;

  // Handshake and stall decode
  always_comb begin
    full         = (out_count == CNT_W'(OUT_DEPTH));
    out_valid    = (out_count != '0);
    out_data     = mem[rd_ptr];
    pop          = out_valid & out_ready;
    push         = cpu_out_wr & (~full | pop);
    blocked_wr   = cpu_out_wr & full & ~pop;
    stall_full   = STALL_ON_FULL & blocked_wr;
    drop         = ~STALL_ON_FULL & blocked_wr;
    stall_in     = BLOCKING_IN & cpu_in_rd & ~hold_valid;
    cpu_stall    = ~RST & (stall_full | stall_in);
    in_ready     = ~RST & (~hold_valid | cpu_in_rd);
    hold_load    = in_valid & in_ready;
    hold_consume = cpu_in_rd & hold_valid;
    cpu_in_data  = hold_valid ? hold_data : '0;
  end

  // FIFO storage has no reset; validity is tracked by out_count
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wr_ptr] <= cpu_out_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_count <= '0;
      out_last  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   out_count <= out_count + CNT_W'(1);
        2'b01:   out_count <= out_count - CNT_W'(1);
        default: out_count <= out_count;
      endcase
      if (cpu_out_wr && !cpu_stall) begin
        out_last <= cpu_out_data;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Input holder: a load in the consume cycle keeps it valid (back-to-back)
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (hold_load) begin
        hold_data  <= in_data;
        hold_valid <= 1'b1;
      end else if (hold_consume) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: default instance (stalling) plus a
// drop-on-full / non-blocking-input instance.
module tb_io_port_unit;

  logic        CLK;
  int          total;
  int          bad;

  // Default-parameter instance
  logic        rst;
  logic        cpu_out_wr;
  logic [15:0] cpu_out_data;
  logic        cpu_in_rd;
  logic [15:0] cpu_in_data;
  logic        cpu_stall;
  logic [15:0] out_last;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  out_count;
  logic        overflow;

  // Drop-on-full, non-blocking-input instance
  logic        d_rst;
  logic        d_cpu_out_wr;
  logic [15:0] d_cpu_out_data;
  logic        d_cpu_in_rd;
  logic [15:0] d_cpu_in_data;
  logic        d_cpu_stall;
  logic [15:0] d_out_last;
  logic [15:0] d_out_data;
  logic        d_out_valid;
  logic        d_out_ready;
  logic [15:0] d_in_data;
  logic        d_in_valid;
  logic        d_in_ready;
  logic [2:0]  d_out_count;
  logic        d_overflow;

  io_port_unit dut (
    .CLK(CLK), .RST(rst),
    .cpu_out_wr(cpu_out_wr), .cpu_out_data(cpu_out_data),
    .cpu_in_rd(cpu_in_rd), .cpu_in_data(cpu_in_data),
    .cpu_stall(cpu_stall), .out_last(out_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_count(out_count), .overflow(overflow)
  );

  io_port_unit #(
    .DATA_WIDTH(16), .OUT_DEPTH(4), .STALL_ON_FULL(1'b0), .BLOCKING_IN(1'b0)
  ) dut_d (
    .CLK(CLK), .RST(d_rst),
    .cpu_out_wr(d_cpu_out_wr), .cpu_out_data(d_cpu_out_data),
    .cpu_in_rd(d_cpu_in_rd), .cpu_in_data(d_cpu_in_data),
    .cpu_stall(d_cpu_stall), .out_last(d_out_last),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .in_data(d_in_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .out_count(d_out_count), .overflow(d_overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; cpu_out_wr = 1'b0; cpu_out_data = '0; cpu_in_rd = 1'b1;
    out_ready = 1'b0; in_data = '0; in_valid = 1'b0;
    d_rst = 1'b1; d_cpu_out_wr = 1'b0; d_cpu_out_data = '0; d_cpu_in_rd = 1'b0;
    d_out_ready = 1'b0; d_in_data = '0; d_in_valid = 1'b0;

    // Reset: stall and in_ready suppressed even with a read of the empty holder
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    cpu_in_rd = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_count", 32'(out_count), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_last", 32'(out_last), 32'd0);
    chk("post_rst_overflow", 32'(overflow), 32'd0);
    chk("post_rst_in_data", 32'(cpu_in_data), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Fill the FIFO with 0x0011..0x0044
    for (int i = 1; i <= 4; i++) begin
      cpu_out_wr = 1'b1;
      cpu_out_data = 16'(i * 'h11);
      #1;
      chk("fill_stall", 32'(cpu_stall), 32'd0);
      tick();
    end
    cpu_out_wr = 1'b0;
    chk("full_count", 32'(out_count), 32'd4);
    chk("full_head", 32'(out_data), 32'h0011);
    chk("full_last", 32'(out_last), 32'h0044);

    // Write to full FIFO stalls and changes nothing
    cpu_out_wr = 1'b1;
    cpu_out_data = 16'h0055;
    #1;
    chk("full_wr_stall", 32'(cpu_stall), 32'd1);
    tick();
    chk("stalled_count", 32'(out_count), 32'd4);
    chk("stalled_last", 32'(out_last), 32'h0044);
    chk("stalled_still", 32'(cpu_stall), 32'd1);

    // Pop cycle lets the held write in
    out_ready = 1'b1;
    #1;
    chk("pop_cycle_stall", 32'(cpu_stall), 32'd0);
    chk("drain_0", 32'(out_data), 32'h0011);
    tick();
    cpu_out_wr = 1'b0;
    chk("pushpop_count", 32'(out_count), 32'd4);
    chk("pushpop_last", 32'(out_last), 32'h0055);
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'((k + 2) * 'h11));
      tick();
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_count", 32'(out_count), 32'd0);

    // Pointer wrap: continuous push with same-cycle pop of the previous value
    for (int i = 0; i < 10; i++) begin
      cpu_out_wr = 1'b1;
      cpu_out_data = 16'(16'h0100 + i);
      #1;
      chk("wrap_stall", 32'(cpu_stall), 32'd0);
      if (i > 0) chk("wrap_data", 32'(out_data), 32'(16'h0100 + i - 1));
      tick();
      chk("wrap_count", 32'(out_count), 32'd1);
    end
    cpu_out_wr = 1'b0;
    #1;
    chk("wrap_last_data", 32'(out_data), 32'h0109);
    tick();
    chk("wrap_end_count", 32'(out_count), 32'd0);
    out_ready = 1'b0;

    // Blocking read of the empty holder
    cpu_in_rd = 1'b1;
    #1;
    chk("in_empty_stall", 32'(cpu_stall), 32'd1);
    chk("in_empty_data", 32'(cpu_in_data), 32'd0);
    tick();
    in_data = 16'h1234;
    in_valid = 1'b1;
    #1;
    chk("in_fill_ready", 32'(in_ready), 32'd1);
    chk("in_no_forward", 32'(cpu_stall), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("in_got_data", 32'(cpu_in_data), 32'h1234);
    chk("in_got_stall", 32'(cpu_stall), 32'd0);

    // Back-to-back consume and refill
    in_data = 16'h5678;
    in_valid = 1'b1;
    #1;
    chk("b2b_ready", 32'(in_ready), 32'd1);
    tick();
    cpu_in_rd = 1'b0;
    in_data = 16'h9999;
    #1;
    chk("b2b_data", 32'(cpu_in_data), 32'h5678);
    chk("full_hold_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("hold_kept", 32'(cpu_in_data), 32'h5678);
    cpu_in_rd = 1'b1;
    tick();
    cpu_in_rd = 1'b0;
    #1;
    chk("consumed_data", 32'(cpu_in_data), 32'd0);
    chk("consumed_ready", 32'(in_ready), 32'd1);

    // Reset mid-drain with three queued entries and a full holder
    in_data = 16'hAAAA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_out_wr = 1'b1;
      cpu_out_data = 16'(16'h0A00 + i);
      tick();
    end
    cpu_out_wr = 1'b0;
    chk("pre_rst_count", 32'(out_count), 32'd3);
    chk("pre_rst_hold", 32'(cpu_in_data), 32'hAAAA);
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(out_count), 32'd0);
    chk("mid_rst_in_data", 32'(cpu_in_data), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_in_ready2", 32'(in_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Drop-on-full instance
    tick();
    d_rst = 1'b0;
    tick();
    chk("d_rst_overflow", 32'(d_overflow), 32'd0);
    d_cpu_in_rd = 1'b1;
    #1;
    chk("d_nonblock_stall", 32'(d_cpu_stall), 32'd0);
    chk("d_nonblock_data", 32'(d_cpu_in_data), 32'd0);
    d_cpu_in_rd = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      d_cpu_out_wr = 1'b1;
      d_cpu_out_data = 16'(i * 'h11);
      tick();
    end
    d_cpu_out_data = 16'hBEEF;
    #1;
    chk("d_full_no_stall", 32'(d_cpu_stall), 32'd0);
    tick();
    d_cpu_out_wr = 1'b0;
    chk("d_overflow_set", 32'(d_overflow), 32'd1);
    chk("d_drop_count", 32'(d_out_count), 32'd4);
    chk("d_drop_last", 32'(d_out_last), 32'hBEEF);
    d_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("d_drain_data", 32'(d_out_data), 32'((k + 1) * 'h11));
      tick();
    end
    d_out_ready = 1'b0;
    chk("d_drained_valid", 32'(d_out_valid), 32'd0);
    chk("d_overflow_sticky", 32'(d_overflow), 32'd1);
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    tick();
    chk("d_overflow_cleared", 32'(d_overflow), 32'd0);
    chk("d_last_cleared", 32'(d_out_last), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
